// File: rtl/mul_div_pkg.sv
// Shared types and execute_type codes for the Mul_Div sequencer.
// Codes 0x10..0x17 are the M-extension ops; the upper half of that range divides.
package mul_div_pkg;

    localparam logic [4:0] EX_MUL    = 5'h10;
    localparam logic [4:0] EX_MULH   = 5'h11;
    localparam logic [4:0] EX_MULHSU = 5'h12;
    localparam logic [4:0] EX_MULHU  = 5'h13;
    localparam logic [4:0] EX_DIV    = 5'h14;
    localparam logic [4:0] EX_DIVU   = 5'h15;
    localparam logic [4:0] EX_REM    = 5'h16;
    localparam logic [4:0] EX_REMU   = 5'h17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Anything outside the M range runs with the multiply window.
    function automatic logic is_div(input logic [4:0] ex_type);
        return (ex_type >= EX_DIV) && (ex_type <= EX_REMU);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-lane round-robin grant; the pointer flips to the other lane on every grant.
// Grants are combinational and only issued while en is high.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic ptr_reg;  // 1 = lane 1 wins on contention

    assign grant0 = en && valid0 && (!valid1 || !ptr_reg);
    assign grant1 = en && valid1 && (!valid0 ||  ptr_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (grant0 || grant1) begin
            ptr_reg <= grant0;
        end
    end

endmodule

// File: rtl/mul_div_sched.sv
// Sequencer for the shared combinational Mul_Div unit: arbitrates two issue lanes,
// holds operands for a fixed window, then returns the registered result with its tag.
module mul_div_sched
    import mul_div_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [31:0]      req0_op1_i,
    input  logic [31:0]      req0_op2_i,
    input  logic [4:0]       req0_type_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [31:0]      req1_op1_i,
    input  logic [31:0]      req1_op2_i,
    input  logic [4:0]       req1_type_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic [31:0]      md_operand1_o,
    output logic [31:0]      md_operand2_o,
    output logic [4:0]       md_execute_type_o,
    input  logic [31:0]      md_result_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [31:0]      wb_result_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic             busy_o
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        op1_reg, op2_reg;
    logic [4:0]         type_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               wb_valid_reg;
    logic [31:0]        wb_result_reg;

    logic               arb_en, grant0, grant1, accept;
    logic [31:0]        sel_op1, sel_op2;
    logic [4:0]         sel_type;
    logic [TAG_W-1:0]   sel_tag;
    logic               window_end;

    assign arb_en = (state_reg == ST_IDLE) && !flush_i;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .valid0 (req0_valid_i),
        .valid1 (req1_valid_i),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign accept   = grant0 || grant1;
    assign sel_op1  = grant1 ? req1_op1_i  : req0_op1_i;
    assign sel_op2  = grant1 ? req1_op2_i  : req0_op2_i;
    assign sel_type = grant1 ? req1_type_i : req0_type_i;
    assign sel_tag  = grant1 ? req1_tag_i  : req0_tag_i;

    assign window_end = (state_reg == ST_BUSY) && (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (accept)     state_next = ST_BUSY;
            ST_BUSY: if (window_end) state_next = ST_DONE;
            ST_DONE: if (wb_ready_i) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand registers survive a flush; only the result path is cancelled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            type_reg      <= '0;
            tag_reg       <= '0;
            wb_valid_reg  <= 1'b0;
            wb_result_reg <= '0;
        end else begin
            if (accept) begin
                op1_reg  <= sel_op1;
                op2_reg  <= sel_op2;
                type_reg <= sel_type;
                tag_reg  <= sel_tag;
                cnt_reg  <= is_div(sel_type) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            end else if ((state_reg == ST_BUSY) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end

            if (flush_i) begin
                wb_valid_reg <= 1'b0;
            end else if (window_end) begin
                wb_valid_reg  <= 1'b1;
                wb_result_reg <= md_result_i;
            end else if ((state_reg == ST_DONE) && wb_ready_i) begin
                wb_valid_reg <= 1'b0;
            end
        end
    end

    assign req0_ready_o      = grant0;
    assign req1_ready_o      = grant1;
    assign md_operand1_o     = op1_reg;
    assign md_operand2_o     = op2_reg;
    assign md_execute_type_o = type_reg;
    assign wb_valid_o        = wb_valid_reg;
    assign wb_result_o       = wb_result_reg;
    assign wb_tag_o          = tag_reg;
    assign busy_o            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mul_div_sched.sv
// Randomized bench for mul_div_sched: a transaction-level model predicts grants,
// timing and results; a scoreboard queue matches retired results against it.
module tb_mul_div_sched;

    localparam int TAG_W      = 4;
    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             req0_valid_i, req1_valid_i;
    logic             req0_ready_o, req1_ready_o;
    logic [31:0]      req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
    logic [4:0]       req0_type_i, req1_type_i;
    logic [TAG_W-1:0] req0_tag_i, req1_tag_i;
    logic [31:0]      md_operand1_o, md_operand2_o, md_result_i;
    logic [4:0]       md_execute_type_o;
    logic             wb_valid_o, wb_ready_i, busy_o;
    logic [31:0]      wb_result_o;
    logic [TAG_W-1:0] wb_tag_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_div_sched #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .TAG_W      (TAG_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush_i),
        .req0_valid_i      (req0_valid_i),
        .req0_ready_o      (req0_ready_o),
        .req0_op1_i        (req0_op1_i),
        .req0_op2_i        (req0_op2_i),
        .req0_type_i       (req0_type_i),
        .req0_tag_i        (req0_tag_i),
        .req1_valid_i      (req1_valid_i),
        .req1_ready_o      (req1_ready_o),
        .req1_op1_i        (req1_op1_i),
        .req1_op2_i        (req1_op2_i),
        .req1_type_i       (req1_type_i),
        .req1_tag_i        (req1_tag_i),
        .md_operand1_o     (md_operand1_o),
        .md_operand2_o     (md_operand2_o),
        .md_execute_type_o (md_execute_type_o),
        .md_result_i       (md_result_i),
        .wb_valid_o        (wb_valid_o),
        .wb_ready_i        (wb_ready_i),
        .wb_result_o       (wb_result_o),
        .wb_tag_o          (wb_tag_o),
        .busy_o            (busy_o)
    );

    // RISC-V M semantics; codes outside the M range return a ^ b.
    function automatic logic [31:0] md_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] t);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (t)
            5'h10: return a * b;
            5'h11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            5'h12: begin p = {{32{a[31]}}, a} * {32'd0, b};        return p[63:32]; end
            5'h13: begin p = {32'd0, a} * {32'd0, b};              return p[63:32]; end
            5'h14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            5'h17: return (b == 0) ? a : a % b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic bit is_div_code(input logic [4:0] t);
        return (t >= 5'h14) && (t <= 5'h17);
    endfunction

    assign md_result_i = md_model(md_operand1_o, md_operand2_o, md_execute_type_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb_q[$];

    // Model: one op outstanding at most; it becomes visible N+1 cycles after accept.
    bit          have_op = 0;
    bit          pref1   = 0;
    int          ready_cycle = 0;
    logic [31:0] h_op1, h_op2;
    logic [4:0]  h_type;

    always @(negedge clk) begin
        bit e_r0, e_r1, e_valid;
        int lat;
        exp_t e;
        if (!rst_n) begin
            have_op = 0;
            pref1   = 0;
        end else begin
            e_r0 = 0;
            e_r1 = 0;
            if (!have_op && !flush_i) begin
                if (req0_valid_i && req1_valid_i) begin
                    e_r0 = !pref1;
                    e_r1 = pref1;
                end else begin
                    e_r0 = req0_valid_i;
                    e_r1 = req1_valid_i;
                end
            end
            e_valid = have_op && (cyc >= ready_cycle);
            chk("req0_ready", {31'd0, req0_ready_o}, {31'd0, e_r0});
            chk("req1_ready", {31'd0, req1_ready_o}, {31'd0, e_r1});
            chk("wb_valid",   {31'd0, wb_valid_o},   {31'd0, e_valid});
            chk("busy",       {31'd0, busy_o},       {31'd0, have_op});
            if (have_op) begin
                chk("md_operand1", md_operand1_o, h_op1);
                chk("md_operand2", md_operand2_o, h_op2);
                chk("md_type", {27'd0, md_execute_type_o}, {27'd0, h_type});
            end
            if (flush_i) begin
                have_op = 0;
            end else if (e_r0 || e_r1) begin
                h_op1  = e_r1 ? req1_op1_i  : req0_op1_i;
                h_op2  = e_r1 ? req1_op2_i  : req0_op2_i;
                h_type = e_r1 ? req1_type_i : req0_type_i;
                e.tag  = e_r1 ? req1_tag_i  : req0_tag_i;
                e.res  = md_model(h_op1, h_op2, h_type);
                sb_q.push_back(e);
                lat = is_div_code(h_type) ? DIV_CYCLES : MUL_CYCLES;
                ready_cycle = cyc + lat + 1;
                have_op = 1;
                pref1 = e_r0;
            end else if (e_valid && wb_ready_i) begin
                have_op = 0;
            end
        end
    end

    // Monitor: every writeback handshake must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush_i) begin
            sb_q.delete();
        end else if (wb_valid_o && wb_ready_i) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL retire_unexpected at cycle %0d: got tag %0d, expected no result",
                         cyc, wb_tag_o);
            end else begin
                e = sb_q.pop_front();
                chk("wb_result", wb_result_o, e.res);
                chk("wb_tag", {28'd0, wb_tag_o}, {28'd0, e.tag});
                $display("retire cycle %0d tag %0d result %h", cyc, wb_tag_o, wb_result_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input bit v, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t, input logic [TAG_W-1:0] g);
        if (lane == 0) begin
            req0_valid_i = v; req0_op1_i = a; req0_op2_i = b; req0_type_i = t; req0_tag_i = g;
        end else begin
            req1_valid_i = v; req1_op1_i = a; req1_op2_i = b; req1_type_i = t; req1_tag_i = g;
        end
    endtask

    task automatic check_all_zero(input string tagname);
        chk({tagname, "_wb_valid"},  {31'd0, wb_valid_o}, 32'd0);
        chk({tagname, "_busy"},      {31'd0, busy_o},     32'd0);
        chk({tagname, "_md_op1"},    md_operand1_o,       32'd0);
        chk({tagname, "_md_op2"},    md_operand2_o,       32'd0);
        chk({tagname, "_md_type"},   {27'd0, md_execute_type_o}, 32'd0);
        chk({tagname, "_wb_result"}, wb_result_o,         32'd0);
        chk({tagname, "_wb_tag"},    {28'd0, wb_tag_o},   32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        int unsigned r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_type();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r < 14) return 5'h10 + 5'(r % 8);
        return 5'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        set_lane(0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Lane 0 MUL 7*6 right after reset release.
        rst_n = 1'b1;
        set_lane(0, 1, 32'd7, 32'd6, 5'h10, 4'd5);
        tick();
        set_lane(0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // Lane 1 DIV -20/3.
        set_lane(1, 1, 32'hFFFF_FFEC, 32'd3, 5'h14, 4'd9);
        tick();
        set_lane(1, 0, 0, 0, 0, 0);
        repeat (11) tick();

        // Both lanes continuously valid: grants must alternate.
        set_lane(0, 1, 32'd3, 32'd5, 5'h10, 4'd1);
        set_lane(1, 1, 32'd11, 32'd13, 5'h10, 4'd2);
        repeat (18) tick();
        set_lane(0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // Writeback stall, with a request waiting on lane 1.
        wb_ready_i = 1'b0;
        set_lane(0, 1, 32'h1234, 32'h10, 5'h13, 4'd3);
        tick();
        set_lane(0, 0, 0, 0, 0, 0);
        set_lane(1, 1, 32'd100, 32'd7, 5'h17, 4'd4);
        repeat (8) tick();
        wb_ready_i = 1'b1;
        tick();
        set_lane(1, 0, 0, 0, 0, 0);
        repeat (12) tick();

        // Flush in the third BUSY cycle of a DIV with lane 1 pending.
        set_lane(0, 1, 32'd20, 32'd3, 5'h14, 4'd6);
        tick();
        set_lane(0, 0, 0, 0, 0, 0);
        set_lane(1, 1, 32'd9, 32'd9, 5'h10, 4'd7);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        set_lane(1, 0, 0, 0, 0, 0);
        repeat (5) tick();

        // Asynchronous reset in the middle of a DIV.
        set_lane(0, 1, 32'd77, 32'd4, 5'h15, 4'd8);
        tick();
        set_lane(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        chk("midrst_req0_ready", {31'd0, req0_ready_o}, 32'd0);
        chk("midrst_req1_ready", {31'd0, req1_ready_o}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_lane(0, 1, 32'd2, 32'd2, 5'h10, 4'd10);
        set_lane(1, 1, 32'd3, 32'd3, 5'h10, 4'd11);
        repeat (10) tick();

        // Random traffic with stalls and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            set_lane(0, ($urandom_range(0, 9) < 6), rand_operand(), rand_operand(),
                     rand_type(), TAG_W'($urandom));
            set_lane(1, ($urandom_range(0, 9) < 6), rand_operand(), rand_operand(),
                     rand_type(), TAG_W'($urandom));
            wb_ready_i = ($urandom_range(0, 9) < 7);
            flush_i    = ($urandom_range(0, 99) < 3);
            tick();
        end

        flush_i    = 1'b0;
        wb_ready_i = 1'b1;
        set_lane(0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0);
        repeat (15) tick();
        chk("drain_queue_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
